// File: rtl/palette_ram.sv
// Double-buffered writable colour palette: two RAM banks, the front one serving 2-cycle lookups
// and the back one taking writes, swapped only on a frame boundary.
module palette_ram #(
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned COLOR_W    = 8,
    parameter bit          TRANSP_EN  = 1'b1,
    parameter int unsigned TRANSP_IDX = 0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    input  logic [IDX_W-1:0]   pix_idx,
    output logic               out_valid,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               out_transparent,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [COLOR_W-1:0] wr_red,
    input  logic [COLOR_W-1:0] wr_green,
    input  logic [COLOR_W-1:0] wr_blue,
    input  logic               swap_req,
    input  logic               frame_start,
    output logic               swap_pending,
    output logic               front_bank,
    output logic               init_busy
);

    localparam int unsigned Depth = 2 ** IDX_W;
    localparam int unsigned DataW = 3 * COLOR_W;

    typedef enum logic [0:0] {StInit = 1'b0, StRun = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             swap_pending_q, swap_pending_d;
    logic             front_bank_q, front_bank_d;
    logic             do_swap;

    logic [DataW-1:0] bank0 [Depth];
    logic [DataW-1:0] bank1 [Depth];

    logic [COLOR_W-1:0] grey_ch;
    logic               we0, we1;
    logic [IDX_W-1:0]   waddr;
    logic [DataW-1:0]   wdata;

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             s1_bank_q;
    logic [DataW-1:0] rd_data;

    // Default fill is grey: the index scaled to the channel width.
    if (IDX_W >= COLOR_W) begin : g_grey_trunc
        assign grey_ch = init_cnt_q[IDX_W-1 -: COLOR_W];
    end else begin : g_grey_pad
        assign grey_ch = {init_cnt_q, {(COLOR_W - IDX_W){1'b0}}};
    end

    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        swap_pending_d = swap_pending_q | swap_req;
        front_bank_d   = front_bank_q;
        do_swap        = 1'b0;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(Depth - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                do_swap = frame_start & (swap_pending_q | swap_req);
            end
            default: state_d = StInit;
        endcase
        if (do_swap) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= StInit;
            init_cnt_q     <= '0;
            swap_pending_q <= 1'b0;
            front_bank_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            swap_pending_q <= swap_pending_d;
            front_bank_q   <= front_bank_d;
        end
    end

    // INIT fills both banks; RUN writes only ever land in the back bank.
    always_comb begin
        we0   = 1'b0;
        we1   = 1'b0;
        waddr = wr_addr;
        wdata = {wr_red, wr_green, wr_blue};
        if (state_q == StInit) begin
            we0   = 1'b1;
            we1   = 1'b1;
            waddr = init_cnt_q;
            wdata = {grey_ch, grey_ch, grey_ch};
        end else if (wr_valid) begin
            we0 = front_bank_q;
            we1 = ~front_bank_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (we0) begin
            bank0[waddr] <= wdata;
        end
        if (we1) begin
            bank1[waddr] <= wdata;
        end
    end

    assign rd_data = s1_bank_q ? bank1[s1_idx_q] : bank0[s1_idx_q];

    // The bank is latched with the index so a swap can never split a lookup.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q      <= 1'b0;
            s1_idx_q        <= '0;
            s1_bank_q       <= 1'b0;
            out_valid       <= 1'b0;
            red             <= '0;
            green           <= '0;
            blue            <= '0;
            out_transparent <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid;
            s1_idx_q   <= pix_idx;
            s1_bank_q  <= front_bank_q;
            out_valid  <= s1_valid_q;
            if (s1_valid_q) begin
                {red, green, blue} <= rd_data;
                out_transparent    <= TRANSP_EN && (s1_idx_q == IDX_W'(TRANSP_IDX));
            end
        end
    end

    assign wr_ready     = (state_q == StRun);
    assign init_busy    = (state_q == StInit);
    assign swap_pending = swap_pending_q;
    assign front_bank   = front_bank_q;

endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: a bank/swap model queues expected lookup results,
// which are popped and compared when out_valid is due.
module tb_palette_ram;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       pix_valid;
    logic [7:0] pix_idx;
    logic       out_valid;
    logic [7:0] red, green, blue;
    logic       out_transparent;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_red, wr_green, wr_blue;
    logic       swap_req;
    logic       frame_start;
    logic       swap_pending;
    logic       front_bank;
    logic       init_busy;

    palette_ram #(
        .IDX_W     (8),
        .COLOR_W   (8),
        .TRANSP_EN (1'b1),
        .TRANSP_IDX(0)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .pix_valid      (pix_valid),
        .pix_idx        (pix_idx),
        .out_valid      (out_valid),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .out_transparent(out_transparent),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_red         (wr_red),
        .wr_green       (wr_green),
        .wr_blue        (wr_blue),
        .swap_req       (swap_req),
        .frame_start    (frame_start),
        .swap_pending   (swap_pending),
        .front_bank     (front_bank),
        .init_busy      (init_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [23:0] data;
        bit          known;
        bit          transp;
    } exp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [23:0] mem   [2][256];
    bit          known [2][256];
    bit          m_run;
    int          m_cnt;
    bit          m_front;
    bit          m_pend;
    exp_t        q[$];
    logic [1:0]  vpipe;
    logic [23:0] last_data;
    bit          last_known;
    bit          last_transp;
    int          busy_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run       = 1'b0;
        m_cnt       = 0;
        m_front     = 1'b0;
        m_pend      = 1'b0;
        vpipe       = 2'b00;
        last_data   = '0;
        last_known  = 1'b1;
        last_transp = 1'b0;
        q.delete();
    endtask

    task automatic check_outputs();
        exp_t e;
        check("out_valid", out_valid, vpipe[1]);
        check("init_busy", init_busy, !m_run);
        check("wr_ready", wr_ready, m_run);
        check("swap_pending", swap_pending, m_pend);
        check("front_bank", front_bank, m_front);
        if (vpipe[1]) begin
            if (q.size() == 0) begin
                check("queue_nonempty", 0, 1);
            end else begin
                e           = q.pop_front();
                last_data   = e.data;
                last_known  = e.known;
                last_transp = e.transp;
            end
        end
        if (last_known) begin
            check("rgb", {red, green, blue}, last_data);
            check("transparent", out_transparent, last_transp);
        end
    endtask

    // Drive one cycle at the falling edge, update the model at the rising edge, check at the next fall.
    task automatic step(input bit pv, input logic [7:0] pidx, input bit wv, input logic [7:0] wa,
                        input logic [23:0] wd, input bit sreq, input bit fs);
        bit          front_pre;
        bit          run_pre;
        logic [7:0]  g;
        exp_t        e;
        pix_valid   = pv;
        pix_idx     = pidx;
        wr_valid    = wv;
        wr_addr     = wa;
        {wr_red, wr_green, wr_blue} = wd;
        swap_req    = sreq;
        frame_start = fs;
        @(posedge Clk);
        front_pre = m_front;
        run_pre   = m_run;
        if (!m_run) begin
            g = m_cnt[7:0];
            for (int b = 0; b < 2; b++) begin
                mem[b][m_cnt]   = {g, g, g};
                known[b][m_cnt] = 1'b1;
            end
            if (m_cnt == 255) m_run = 1'b1;
            m_cnt++;
        end else if (wv) begin
            mem[!front_pre][wa]   = wd;
            known[!front_pre][wa] = 1'b1;
        end
        if (run_pre && fs && (m_pend || sreq)) begin
            m_front = !m_front;
            m_pend  = 1'b0;
        end else begin
            m_pend = m_pend | sreq;
        end
        if (pv) begin
            e.data   = mem[front_pre][pidx];
            e.known  = known[front_pre][pidx];
            e.transp = (pidx == 8'h00);
            q.push_back(e);
        end
        vpipe = {vpipe[0], pv};
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 24'h0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) known[b][i] = 1'b0;
        pix_valid = 0; pix_idx = 0; wr_valid = 0; wr_addr = 0;
        wr_red = 0; wr_green = 0; wr_blue = 0; swap_req = 0; frame_start = 0;
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        check_outputs();
        Reset_n = 1'b1;

        // Power-up fill with a constant 0x80 lookup running; swap_req during INIT must stay pending.
        busy_cnt = init_busy ? 1 : 0;
        for (int i = 0; i < 260; i++) begin
            step(1, 8'h80, 1, 8'h10, 24'hdead00, (i == 50), (i == 60));
            if (init_busy) busy_cnt++;
        end
        check("init_len", busy_cnt, 256);
        check("grey80", {red, green, blue}, 24'h808080);
        check("pend_after_init", swap_pending, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("swap_after_init", front_bank, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("swap_back", front_bank, 0);
        idle(2);

        // Transparency only on index 0.
        step(1, 8'h00, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
        check("transp_idx00", out_transparent, 1);
        step(1, 8'h01, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
        check("transp_idx01", out_transparent, 0);
        step(1, 8'hff, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
        check("grey_ff", {red, green, blue}, 24'hffffff);

        // A back-bank write is invisible until the swap.
        step(1, 8'h05, 1, 8'h05, 24'h123456, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h05, 0, 0, 0, 0, 0);
        check("no_tear_05", {red, green, blue}, 24'h050505);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("front_after_swap", front_bank, 1);
        step(1, 8'h05, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
        check("new_05", {red, green, blue}, 24'h123456);

        // Repeated swap requests collapse into one toggle.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
        check("pend_multi", swap_pending, 1);
        check("front_hold", front_bank, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("single_toggle", front_bank, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("no_second_toggle", front_bank, 0);

        // Write and swap in the same cycle: the write lands in the bank that becomes front.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 8'h33, 24'haabbcc, 0, 1);
        step(1, 8'h33, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
        check("write_at_swap", {red, green, blue}, 24'haabbcc);

        // Distinct back-bank contents, then a full streaming sweep across a swap edge.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            step(1, 8'(255 - i), 1, a, {a ^ 8'h5a, a, ~a}, 0, 0);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) step(1, 8'(i), 0, 0, 0, 0, (i == 100));
        idle(3);
        check("queue_drained", q.size(), 0);

        // Asynchronous reset mid-RUN with a swap pending and lookups in flight.
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 8'h07, 0, 0, 0, 0, 0);
        pix_valid = 1'b1; pix_idx = 8'h09;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        model_reset();
        #1 check_outputs();
        check("rst_pending", swap_pending, 0);
        @(posedge Clk);
        @(negedge Clk);
        check_outputs();
        Reset_n = 1'b1;
        busy_cnt = init_busy ? 1 : 0;
        for (int i = 0; i < 258; i++) begin
            step(1, 8'($urandom_range(0, 255)), 0, 0, 0, (i == 10), (i == 20));
            if (init_busy) busy_cnt++;
        end
        check("reinit_len", busy_cnt, 256);
        check("reinit_pend", swap_pending, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("reinit_swap", front_bank, 1);
        idle(3);
        check("queue_final", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
